// File: rtl/fwrisc_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// fwrisc_mem_responder_pkg : shared types and constants for the memory responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fwrisc_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  localparam int          WAIT_CNT_W  = 5;
  localparam logic [15:0] LFSR_SEED_I = 16'hACE1;
  localparam logic [15:0] LFSR_SEED_D = 16'h1D2C;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwrisc_mem_responder_port.sv
// ---------------------------------------------------------------------------
// fwrisc_mem_responder_port : per-port IDLE/WAIT/RESP handshake FSM and wait counter
// Optional random stall: FWRISC_MEM_RESPONDER_RAND_WAIT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwrisc_mem_responder_port
  import fwrisc_mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
`ifdef FWRISC_MEM_RESPONDER_RAND_WAIT_EN
  ,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_I
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  output logic capture,
  output logic fire
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

  resp_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_CNT_W-1:0] wait_ld;

`ifdef FWRISC_MEM_RESPONDER_RAND_WAIT_EN
  logic [15:0] lfsr_q;

  assign wait_ld = WAIT_LD + WAIT_CNT_W'(lfsr_q[1:0]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else if (capture) lfsr_q <= lfsr_next(lfsr_q);
  end
`else
  assign wait_ld = WAIT_LD;
`endif

  // fire marks the edge that enters RESP; the top does its array access there
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && reset) begin
          capture = 1'b1;
          if (wait_ld == '0) begin
            fire    = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = wait_ld;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= WAIT_CNT_W'(1)) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwrisc_mem_responder.sv
// ---------------------------------------------------------------------------
// fwrisc_mem_responder : fwrisc I/D bus responder backed by a word array
// Optional random stall: FWRISC_MEM_RESPONDER_RAND_WAIT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwrisc_mem_responder
  import fwrisc_mem_responder_pkg::*;
#(
  parameter int    ADDR_BITS = 12,
  parameter int    IWAIT     = 0,
  parameter int    DWAIT     = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  input  logic        ivalid,
  output logic        iready,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  input  logic [3:0]  dstrb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic        dready
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  logic i_cap, i_fire, d_cap, d_fire;

  fwrisc_mem_responder_port #(
    .WAIT_CYCLES(IWAIT)
`ifdef FWRISC_MEM_RESPONDER_RAND_WAIT_EN
    , .LFSR_SEED(LFSR_SEED_I)
`endif
  ) u_iport (
    .clock  (clock),
    .reset  (reset),
    .valid  (ivalid),
    .capture(i_cap),
    .fire   (i_fire)
  );

  fwrisc_mem_responder_port #(
    .WAIT_CYCLES(DWAIT)
`ifdef FWRISC_MEM_RESPONDER_RAND_WAIT_EN
    , .LFSR_SEED(LFSR_SEED_D)
`endif
  ) u_dport (
    .clock  (clock),
    .reset  (reset),
    .valid  (dvalid),
    .capture(d_cap),
    .fire   (d_fire)
  );

  logic [ADDR_BITS-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic                 d_we_q, d_we_d;
  logic [3:0]           d_strb_q, d_strb_d;
  logic [31:0]          d_wdata_q, d_wdata_d;
  logic                 iready_q, iready_d, dready_q, dready_d;
  logic [31:0]          idata_q, idata_d, drdata_q, drdata_d;

  // The _d side of the capture registers is the live request on a zero-wait
  // accept, so the same address feeds the array on that edge.
  always_comb begin
    i_addr_d  = i_cap ? iaddr[ADDR_BITS+1:2] : i_addr_q;
    d_addr_d  = d_cap ? daddr[ADDR_BITS+1:2] : d_addr_q;
    d_we_d    = d_cap ? dwrite : d_we_q;
    d_strb_d  = d_cap ? dstrb  : d_strb_q;
    d_wdata_d = d_cap ? dwdata : d_wdata_q;
    iready_d  = i_fire;
    dready_d  = d_fire;
    idata_d   = i_fire ? mem[i_addr_d] : idata_q;
    drdata_d  = d_fire ? mem[d_addr_d] : drdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_we_q    <= 1'b0;
      d_strb_q  <= '0;
      d_wdata_q <= '0;
      iready_q  <= 1'b0;
      dready_q  <= 1'b0;
      idata_q   <= '0;
      drdata_q  <= '0;
    end else begin
      i_addr_q  <= i_addr_d;
      d_addr_q  <= d_addr_d;
      d_we_q    <= d_we_d;
      d_strb_q  <= d_strb_d;
      d_wdata_q <= d_wdata_d;
      iready_q  <= iready_d;
      dready_q  <= dready_d;
      idata_q   <= idata_d;
      drdata_q  <= drdata_d;
    end
  end

  // Array is not reset; reads above sample the pre-write word on the same edge
  always_ff @(posedge clock) begin
    if (d_fire && d_we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (d_strb_d[b]) mem[d_addr_d][8*b +: 8] <= d_wdata_d[8*b +: 8];
      end
    end
  end

  assign iready = iready_q;
  assign dready = dready_q;
  assign idata  = idata_q;
  assign drdata = drdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[1:0], iaddr[31:ADDR_BITS+2],
                              daddr[1:0], daddr[31:ADDR_BITS+2]};

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_fwrisc_mem_responder : directed self-checking bench, zero-wait and waited instances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fwrisc_mem_responder;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [1:0][31:0] iaddr, idata, daddr, dwdata, drdata;
  logic [1:0][3:0]  dstrb;
  logic [1:0]       ivalid, iready, dwrite, dvalid, dready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  fwrisc_mem_responder #(.ADDR_BITS(12), .IWAIT(0), .DWAIT(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .iaddr(iaddr[0]), .idata(idata[0]), .ivalid(ivalid[0]), .iready(iready[0]),
    .daddr(daddr[0]), .dwdata(dwdata[0]), .drdata(drdata[0]), .dstrb(dstrb[0]),
    .dwrite(dwrite[0]), .dvalid(dvalid[0]), .dready(dready[0])
  );

  fwrisc_mem_responder #(.ADDR_BITS(12), .IWAIT(2), .DWAIT(4)) u_dut1 (
    .clock(clock), .reset(reset),
    .iaddr(iaddr[1]), .idata(idata[1]), .ivalid(ivalid[1]), .iready(iready[1]),
    .daddr(daddr[1]), .dwdata(dwdata[1]), .drdata(drdata[1]), .dstrb(dstrb[1]),
    .dwrite(dwrite[1]), .dvalid(dvalid[1]), .dready(dready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic d_txn(input int u, input logic wr, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int lat);
    daddr[u] = addr; dwrite[u] = wr; dstrb[u] = strb; dwdata[u] = wdata;
    dvalid[u] = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!dready[u] && lat < 40);
    rdata = drdata[u];
    check("d_done", 32'(dready[u]), 32'd1);
    dvalid[u] = 1'b0;
    step();
  endtask

  task automatic i_txn(input int u, input logic [31:0] addr,
                       output logic [31:0] rdata, output int lat);
    iaddr[u] = addr; ivalid[u] = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!iready[u] && lat < 40);
    rdata = idata[u];
    check("i_done", 32'(iready[u]), 32'd1);
    ivalid[u] = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat;
    iaddr = '0; daddr = '0; dwdata = '0; dstrb = '0;
    ivalid = '0; dwrite = '0; dvalid = '0;

    // Reset held with requests pending on the zero-wait instance
    ivalid[0] = 1'b1; dvalid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_iready", 32'(iready[0]), 32'd0);
      check("rst_dready", 32'(dready[0]), 32'd0);
      check("rst_idata",  idata[0], 32'd0);
      check("rst_drdata", drdata[0], 32'd0);
    end
    reset = 1'b1;
    step();
    check("post_rst_iready", 32'(iready[0]), 32'd1);
    check("post_rst_dready", 32'(dready[0]), 32'd1);
    ivalid[0] = 1'b0; dvalid[0] = 1'b0;
    step();
    check("iready_one_cycle", 32'(iready[0]), 32'd0);

    // Waited instance: DWAIT=4 store latency, then IWAIT=2 fetch timing
    d_txn(1, 1'b1, 32'h10, 4'hF, 32'h00B50533, rd, lat);
    check("dwait4_lat", 32'(lat), 32'd5);
    iaddr[1] = 32'h10; ivalid[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("iwait2_rdy", 32'(iready[1]), 32'(k == 3));
      if (k == 3) begin
        check("iwait2_data", idata[1], 32'h00B50533);
        ivalid[1] = 1'b0;
      end
    end

    // Byte-lane store, pre-write read data, zero strobe, strobe ignored on load
    d_txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, lat);
    check("dwait0_lat", 32'(lat), 32'd1);
    d_txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, lat);
    check("store_prewrite", rd, 32'h11223344);
    d_txn(0, 1'b0, 32'h20, 4'b0000, 32'h0, rd, lat);
    check("byte_lanes", rd, 32'h11BB33DD);
    d_txn(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, rd, lat);
    d_txn(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    check("strb_zero", rd, 32'h11BB33DD);

    // Same-word fetch and store completing together
    d_txn(0, 1'b1, 32'h8, 4'hF, 32'h0, rd, lat);
    iaddr[0] = 32'h8; ivalid[0] = 1'b1;
    daddr[0] = 32'h8; dwrite[0] = 1'b1; dstrb[0] = 4'hF; dwdata[0] = 32'hDEADBEEF;
    dvalid[0] = 1'b1;
    step();
    check("coll_iready", 32'(iready[0]), 32'd1);
    check("coll_dready", 32'(dready[0]), 32'd1);
    check("coll_idata_old", idata[0], 32'h0);
    check("coll_drdata_old", drdata[0], 32'h0);
    ivalid[0] = 1'b0; dvalid[0] = 1'b0;
    step();
    i_txn(0, 32'h8, rd, lat);
    check("coll_fetch_new", rd, 32'hDEADBEEF);
    check("iwait0_lat", 32'(lat), 32'd1);

    // Back-to-back fetches with ivalid held high
    d_txn(0, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, rd, lat);
    iaddr[0] = 32'h20; ivalid[0] = 1'b1;
    step();
    check("b2b_rdy1", 32'(iready[0]), 32'd1);
    check("b2b_data1", idata[0], 32'h11BB33DD);
    iaddr[0] = 32'h30;
    step();
    check("b2b_gap", 32'(iready[0]), 32'd0);
    step();
    check("b2b_rdy2", 32'(iready[0]), 32'd1);
    check("b2b_data2", idata[0], 32'hCAFEF00D);
    ivalid[0] = 1'b0;
    step();

    // Address wrap modulo array depth
    d_txn(0, 1'b1, 32'h4000, 4'hF, 32'h5A5A5A5A, rd, lat);
    d_txn(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat);
    check("wrap_alias", rd, 32'h5A5A5A5A);

    // Reset during WAIT aborts the store and its ready pulse
    d_txn(1, 1'b1, 32'h0, 4'hF, 32'h12345678, rd, lat);
    daddr[1] = 32'h0; dwrite[1] = 1'b1; dstrb[1] = 4'hF; dwdata[1] = 32'hFFFFFFFF;
    dvalid[1] = 1'b1;
    step();
    step();
    check("abort_wait_rdy", 32'(dready[1]), 32'd0);
    reset = 1'b0;
    dvalid[1] = 1'b0;
    step();
    check("abort_in_rst", 32'(dready[1]), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_rdy", 32'(dready[1]), 32'd0);
    end
    d_txn(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat);
    check("abort_no_write", rd, 32'h12345678);
    check("dwait4_lat_load", 32'(lat), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
